level_mod_3l: RTL and testbench

Three-level modulator front end between the `pwm16bits` carrier comparators and the `decoder_3lxnpc` switch decoder. It takes two level-shifted comparator outputs and debounces the requested level. It enforces a minimum dwell per level and forces a timed pass through zero on every P↔N reversal. The result is the 2-bit `v_lev` command the decoder consumes.

---
 rtl/level_mod_3l.sv | 157 +++++++++++++++
 tb/tb_level_mod_3l.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/level_mod_3l.sv
// Three-level modulator front end: decodes the two carrier comparators, filters the request,
// enforces per-level dwell and a timed zero pass on every P<->N reversal.
module level_mod_3l #(
    parameter int unsigned W_T = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce,
    input  logic           en,
    input  logic           sig_hi,
    input  logic           sig_lo,
    input  logic [W_T-1:0] t_filt,
    input  logic [W_T-1:0] t_min,
    input  logic [W_T-1:0] t_zero,
    input  logic           err_clr,
    output logic [1:0]     v_lev,
    output logic           lev_chg,
    output logic           err
);

    localparam logic [1:0]     LevZ   = 2'b00;
    localparam logic [1:0]     LevP   = 2'b01;
    localparam logic [1:0]     LevN   = 2'b10;
    localparam logic [W_T-1:0] CntMax = {W_T{1'b1}};

    typedef enum logic [1:0] {StZero, StPos, StNeg, StZpass} state_e;

    state_e         state_q, state_d;
    logic [1:0]     req_q, req_d, req_f_q, req_f;
    logic [W_T-1:0] filt_q, filt_d;
    logic [W_T-1:0] dwell_q, dwell_d;
    logic [W_T-1:0] zero_min;
    logic           err_q, err_d;
    logic           lev_chg_q;
    logic           inv;
    logic           dwell_ok;
    logic           chg;
    logic [1:0]     lev_q, lev_d;

    always_comb begin
        inv   = sig_hi & ~sig_lo;
        req_d = LevZ;
        if (en) begin
            case ({sig_hi, sig_lo})
                2'b11:   req_d = LevP;
                2'b00:   req_d = LevN;
                default: req_d = LevZ;
            endcase
        end
    end

    // The filter count restarts on the same edge that registers a new request.
    always_comb begin
        filt_d = filt_q;
        if (req_d != req_q) begin
            filt_d = '0;
        end else if (filt_q != CntMax) begin
            filt_d = filt_q + W_T'(1);
        end
        req_f = (filt_q >= t_filt) ? req_q : req_f_q;
    end

    always_comb begin
        zero_min = t_min;
        if (t_zero > zero_min) begin
            zero_min = t_zero;
        end
        if (zero_min == '0) begin
            zero_min = W_T'(1);
        end
        dwell_ok = (dwell_q >= t_min);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StZero: begin
                if (dwell_ok && req_f == LevP) state_d = StPos;
                else if (dwell_ok && req_f == LevN) state_d = StNeg;
            end
            StPos: begin
                if (dwell_ok && req_f == LevZ) state_d = StZero;
                else if (dwell_ok && req_f == LevN) state_d = StZpass;
            end
            StNeg: begin
                if (dwell_ok && req_f == LevZ) state_d = StZero;
                else if (dwell_ok && req_f == LevP) state_d = StZpass;
            end
            StZpass: begin
                // Exit target follows the request at exit time.
                if (dwell_q >= zero_min) begin
                    case (req_f)
                        LevP:    state_d = StPos;
                        LevN:    state_d = StNeg;
                        default: state_d = StZero;
                    endcase
                end
            end
            default: state_d = StZero;
        endcase
    end

    always_comb begin
        lev_q = LevZ;
        case (state_q)
            StPos:   lev_q = LevP;
            StNeg:   lev_q = LevN;
            default: lev_q = LevZ;
        endcase
        lev_d = LevZ;
        case (state_d)
            StPos:   lev_d = LevP;
            StNeg:   lev_d = LevN;
            default: lev_d = LevZ;
        endcase
        chg     = (lev_d != lev_q);
        dwell_d = dwell_q;
        if (chg) begin
            dwell_d = W_T'(1);
        end else if (dwell_q != CntMax) begin
            dwell_d = dwell_q + W_T'(1);
        end
        err_d = err_q;
        if (inv) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StZero;
            req_q     <= LevZ;
            req_f_q   <= LevZ;
            filt_q    <= '0;
            dwell_q   <= CntMax;
            err_q     <= 1'b0;
            lev_chg_q <= 1'b0;
        end else begin
            lev_chg_q <= ce & chg;
            if (ce) begin
                state_q <= state_d;
                req_q   <= req_d;
                req_f_q <= req_f;
                filt_q  <= filt_d;
                dwell_q <= dwell_d;
                err_q   <= err_d;
            end
        end
    end

    assign v_lev   = lev_q;
    assign lev_chg = lev_chg_q;
    assign err     = err_q;

endmodule

// File: tb/tb_level_mod_3l.sv
// Directed bench for level_mod_3l with hand-computed expectations.
module tb_level_mod_3l;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic       en;
    logic       sig_hi;
    logic       sig_lo;
    logic [7:0] t_filt;
    logic [7:0] t_min;
    logic [7:0] t_zero;
    logic       err_clr;
    logic [1:0] v_lev;
    logic       lev_chg;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    level_mod_3l #(.W_T(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce),
        .en     (en),
        .sig_hi (sig_hi),
        .sig_lo (sig_lo),
        .t_filt (t_filt),
        .t_min  (t_min),
        .t_zero (t_zero),
        .err_clr(err_clr),
        .v_lev  (v_lev),
        .lev_chg(lev_chg),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_sig(input logic hi, input logic lo);
        sig_hi = hi;
        sig_lo = lo;
    endtask

    logic seen;

    initial begin
        rst = 1'b0; ce = 1'b1; en = 1'b1; err_clr = 1'b0;
        t_filt = 8'd0; t_min = 8'd0; t_zero = 8'd0;
        set_sig(1'b0, 1'b1);
        tick(3);
        check("rst_vlev", 32'(v_lev), 32'd0);
        check("rst_chg", 32'(lev_chg), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        tick(3);

        // Basic mapping: P, Z, N each two clocks after the input.
        set_sig(1'b1, 1'b1);
        tick(1);
        check("p_lat1", 32'(v_lev), 32'd0);
        tick(1);
        check("p_lat2", 32'(v_lev), 32'd1);
        check("p_chg", 32'(lev_chg), 32'd1);
        tick(1);
        check("p_chg_once", 32'(lev_chg), 32'd0);
        set_sig(1'b0, 1'b1);
        tick(1);
        check("z_lat1", 32'(v_lev), 32'd1);
        tick(1);
        check("z_lat2", 32'(v_lev), 32'd0);
        check("z_chg", 32'(lev_chg), 32'd1);
        tick(1);
        set_sig(1'b0, 1'b0);
        tick(2);
        check("n_lat2", 32'(v_lev), 32'd2);
        check("n_chg", 32'(lev_chg), 32'd1);
        tick(1);
        check("n_chg_once", 32'(lev_chg), 32'd0);
        set_sig(1'b0, 1'b1);
        tick(4);
        check("back_z", 32'(v_lev), 32'd0);

        // Glitch reject with t_filt=3.
        t_filt = 8'd3;
        tick(2);
        set_sig(1'b1, 1'b1);
        seen = 1'b0;
        tick(3);
        seen = seen | (v_lev != 2'd0);
        set_sig(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            seen = seen | (v_lev != 2'd0) | lev_chg;
        end
        check("glitch_rej", 32'(seen), 32'd0);
        set_sig(1'b1, 1'b1);
        tick(4);
        check("filt_lat4", 32'(v_lev), 32'd0);
        tick(1);
        check("filt_lat5", 32'(v_lev), 32'd1);
        tick(5);
        t_filt = 8'd0;
        set_sig(1'b0, 1'b1);
        tick(4);
        check("filt_back_z", 32'(v_lev), 32'd0);

        // Reversal P -> N through an 8-cycle zero.
        t_min = 8'd2; t_zero = 8'd8;
        set_sig(1'b1, 1'b1);
        tick(2);
        check("rev_p", 32'(v_lev), 32'd1);
        tick(4);
        set_sig(1'b0, 1'b0);
        tick(1);
        check("rev_hold_p", 32'(v_lev), 32'd1);
        tick(1);
        check("rev_zp_in", 32'(v_lev), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            seen = seen | (v_lev != 2'd0);
        end
        check("rev_zero8", 32'(seen), 32'd0);
        tick(1);
        check("rev_n", 32'(v_lev), 32'd2);
        check("rev_n_chg", 32'(lev_chg), 32'd1);

        // Reversal N -> P.
        tick(3);
        set_sig(1'b1, 1'b1);
        tick(9);
        check("rev2_zero", 32'(v_lev), 32'd0);
        tick(1);
        check("rev2_p", 32'(v_lev), 32'd1);

        // Retarget: P -> ZPASS toward N, request returns to P mid-pass.
        tick(3);
        set_sig(1'b0, 1'b0);
        tick(2);
        check("rt_zp_in", 32'(v_lev), 32'd0);
        tick(2);
        set_sig(1'b1, 1'b1);
        tick(5);
        check("rt_zero", 32'(v_lev), 32'd0);
        tick(1);
        check("rt_p", 32'(v_lev), 32'd1);
        check("rt_chg", 32'(lev_chg), 32'd1);

        // Invalid combination and sticky error.
        tick(3);
        set_sig(1'b1, 1'b0);
        tick(1);
        check("inv_err", 32'(err), 32'd1);
        set_sig(1'b0, 1'b1);
        tick(1);
        check("inv_vlev", 32'(v_lev), 32'd0);
        check("inv_sticky", 32'(err), 32'd1);
        err_clr = 1'b1;
        tick(1);
        check("clr_err", 32'(err), 32'd0);
        set_sig(1'b1, 1'b0);
        tick(1);
        check("set_wins", 32'(err), 32'd1);
        err_clr = 1'b0;
        set_sig(1'b0, 1'b1);
        tick(1);
        check("err_hold", 32'(err), 32'd1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;

        // Clock-enable freeze during ZPASS.
        set_sig(1'b1, 1'b1);
        tick(2);
        check("ce_p", 32'(v_lev), 32'd1);
        tick(3);
        set_sig(1'b0, 1'b0);
        tick(2);
        check("ce_zp_chg", 32'(lev_chg), 32'd1);
        ce = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            seen = seen | lev_chg | (v_lev != 2'd0);
        end
        check("ce_frozen", 32'(seen), 32'd0);
        ce = 1'b1;
        tick(7);
        check("ce_resume_zero", 32'(v_lev), 32'd0);
        tick(1);
        check("ce_resume_n", 32'(v_lev), 32'd2);

        // Asynchronous reset in mid-ZPASS.
        tick(3);
        set_sig(1'b1, 1'b1);
        tick(2);
        check("rz_chg", 32'(lev_chg), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rz_vlev", 32'(v_lev), 32'd0);
        check("rz_chg0", 32'(lev_chg), 32'd0);
        tick(1);
        rst = 1'b1;
        tick(1);
        check("rz_lat1", 32'(v_lev), 32'd0);
        tick(1);
        check("rz_lat2", 32'(v_lev), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
